// File: rtl/byte_loader.sv
// rtl/byte_loader.sv - multi-cycle byte extraction engine for the DBM load path
module byte_loader (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic        incr,
  input  logic [0:35] word,
  input  logic [0:5]  bpPOS,
  input  logic [0:5]  bpSIZE,
  input  logic        nextVALID,
  input  logic [0:35] nextWORD,
  output logic        busy,
  output logic        needNEXT,
  output logic        wordADV,
  output logic        done,
  output logic [0:35] byteOUT,
  output logic [0:5]  newPOS
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_INCR  = 3'd1,
    S_WAITW = 3'd2,
    S_SHIFT = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [35:0] shreg_q, shreg_d;
  logic [5:0]  pos_q, pos_d;
  logic [5:0]  size_q, size_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        busy_q, busy_d;
  logic        need_q, need_d;
  logic        wadv_q, wadv_d;
  logic        done_q, done_d;
  logic [35:0] byte_q, byte_d;
  logic [5:0]  newpos_q, newpos_d;
  logic [5:0]  pos_new;
  logic [35:0] mask;

  function automatic logic [5:0] cap36(input logic [5:0] p);
    return (p > 6'd36) ? 6'd36 : p;
  endfunction

  assign mask = (size_q >= 6'd36) ? {36{1'b1}} : ~({36{1'b1}} << size_q);

  always_comb begin
    state_d  = state_q;
    shreg_d  = shreg_q;
    pos_d    = pos_q;
    size_d   = size_q;
    cnt_d    = cnt_q;
    wadv_d   = wadv_q;
    byte_d   = byte_q;
    newpos_d = newpos_q;
    pos_new  = pos_q;
    unique case (state_q)
      S_IDLE: begin
        if (start) begin
          shreg_d = word;
          pos_d   = bpPOS;
          size_d  = bpSIZE;
          wadv_d  = 1'b0;
          if (incr) begin
            state_d = S_INCR;
          end else begin
            state_d = S_SHIFT;
            cnt_d   = cap36(bpPOS);
          end
        end
      end
      S_INCR: begin
        if (pos_q >= size_q) begin
          pos_new = pos_q - size_q;
          state_d = S_SHIFT;
        end else begin
          // Pointer wrapped: restart at the first byte of the following word.
          pos_new = (size_q >= 6'd36) ? 6'd0 : 6'd36 - size_q;
          wadv_d  = 1'b1;
          state_d = S_WAITW;
        end
        pos_d = pos_new;
        cnt_d = cap36(pos_new);
      end
      S_WAITW: begin
        if (nextVALID) begin
          shreg_d = nextWORD;
          state_d = S_SHIFT;
        end
      end
      S_SHIFT: begin
        if (cnt_q != 6'd0) begin
          shreg_d = shreg_q >> 1;
          cnt_d   = cnt_q - 6'd1;
        end else begin
          byte_d   = shreg_q & mask;
          newpos_d = pos_q;
          state_d  = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    // Status outputs trail the state by one cycle; busy also covers the done pulse.
    busy_d = (state_d != S_IDLE) || (state_q == S_DONE);
    need_d = (state_q == S_WAITW) && (state_d == S_WAITW);
    done_d = (state_q == S_DONE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= S_IDLE;
      shreg_q  <= '0;
      pos_q    <= '0;
      size_q   <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      need_q   <= 1'b0;
      wadv_q   <= 1'b0;
      done_q   <= 1'b0;
      byte_q   <= '0;
      newpos_q <= '0;
    end else begin
      state_q  <= state_d;
      shreg_q  <= shreg_d;
      pos_q    <= pos_d;
      size_q   <= size_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      need_q   <= need_d;
      wadv_q   <= wadv_d;
      done_q   <= done_d;
      byte_q   <= byte_d;
      newpos_q <= newpos_d;
    end
  end

  assign busy     = busy_q;
  assign needNEXT = need_q;
  assign wordADV  = wadv_q;
  assign done     = done_q;
  assign byteOUT  = byte_q;
  assign newPOS   = newpos_q;

endmodule

// File: tb/tb_byte_loader.sv
// tb/tb_byte_loader.sv - randomized self-checking bench for byte_loader
module tb_byte_loader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        incr = 1'b0;
  logic        nextVALID = 1'b0;
  logic [0:35] word = '0;
  logic [0:35] nextWORD = '0;
  logic [0:5]  bpPOS = '0;
  logic [0:5]  bpSIZE = '0;
  logic        busy, needNEXT, wordADV, done;
  logic [0:35] byteOUT;
  logic [0:5]  newPOS;

  int n_checks = 0;
  int n_pass   = 0;

  byte_loader dut (
    .rst(rst), .clk(clk), .start(start), .incr(incr), .word(word),
    .bpPOS(bpPOS), .bpSIZE(bpSIZE), .nextVALID(nextVALID), .nextWORD(nextWORD),
    .busy(busy), .needNEXT(needNEXT), .wordADV(wordADV), .done(done),
    .byteOUT(byteOUT), .newPOS(newPOS)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0o expected %0o", tag, got, exp);
  endtask

  function automatic logic [35:0] rand36();
    logic [63:0] t;
    t = {$urandom(), $urandom()};
    return t[35:0];
  endfunction

  // Reference: one LDB/ILDB operation computed straight from the pointer rules.
  task automatic run_op(input logic [35:0] w, input int p, input int s, input bit inc,
                        input logic [35:0] nw, input int dly, input int poke_in);
    int pn, cnt, exp_done, nedge, done_edge, need_first, poke, extra, watch;
    bit wrap;
    logic [63:0] m, src, eb;
    wrap = inc && (p < s);
    pn   = !inc ? p : (p >= s ? p - s : (s >= 36 ? 0 : 36 - s));
    cnt  = (pn > 36) ? 36 : pn;
    m    = (s >= 36) ? 64'hF_FFFF_FFFF : (64'd1 << s) - 64'd1;
    src  = wrap ? {28'd0, nw} : {28'd0, w};
    eb   = (src >> pn) & m;
    exp_done = wrap ? 0 : (inc ? cnt + 3 : cnt + 2);
    poke = poke_in;
    if (wrap && poke > 4) poke = 4;
    if (!wrap && poke >= exp_done) poke = exp_done - 1;

    @(negedge clk);
    word = w; bpPOS = p[5:0]; bpSIZE = s[5:0]; incr = inc;
    nextWORD = nw; nextVALID = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    word = rand36(); bpPOS = 6'($urandom); bpSIZE = 6'($urandom); incr = 1'($urandom);
    done_edge = -1; nedge = -1; need_first = -1;
    for (int k = 1; k <= 300 && done_edge < 0; k++) begin
      if (!wrap) begin
        nextVALID = 1'($urandom);
        nextWORD  = rand36();
      end
      @(posedge clk); #1;
      if (k == nedge) nextVALID = 1'b0;
      if (needNEXT && need_first < 0) need_first = k;
      if (wrap && needNEXT && nedge < 0 && k - need_first == dly) begin
        nextVALID = 1'b1;
        nedge     = k + 1;
        exp_done  = nedge + cnt + 2;
      end
      start = (poke > 0 && k == poke);
      if (done) done_edge = k;
    end
    start = 1'b0;
    nextVALID = 1'b0;
    chk("latency", 64'(done_edge), 64'(exp_done));
    chk("byteOUT", {28'd0, byteOUT}, eb);
    chk("newPOS", {58'd0, newPOS}, 64'(pn));
    chk("wordADV", {63'd0, wordADV}, {63'd0, wrap});
    chk("need_rise", 64'(need_first), wrap ? 64'd2 : 64'hFFFF_FFFF_FFFF_FFFF);
    chk("busy_in_done", {63'd0, busy}, 64'd1);
    @(posedge clk); #1;
    chk("done_pulse_len", {63'd0, done}, 64'd0);
    chk("idle_busy", {63'd0, busy}, 64'd0);
    extra = 0;
    watch = (poke > 0) ? 45 : 2;
    for (int k = 0; k < watch; k++) begin
      @(posedge clk); #1;
      if (done || busy) extra++;
    end
    chk("no_extra_done", 64'(extra), 64'd0);
    chk("wordADV_held", {63'd0, wordADV}, {63'd0, wrap});
  endtask

  initial begin
    int quiet;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    chk("rst_busy", {63'd0, busy}, 64'd0);
    chk("rst_need", {63'd0, needNEXT}, 64'd0);
    chk("rst_wadv", {63'd0, wordADV}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    chk("rst_byte", {28'd0, byteOUT}, 64'd0);
    chk("rst_pos", {58'd0, newPOS}, 64'd0);

    run_op(36'o123456701234, 30, 6, 1'b0, 36'd0, 0, 0);
    run_op(36'o123456701234, 6, 6, 1'b1, 36'd0, 0, 0);

    // Abort mid-shift with a long P, then confirm nothing ever completes.
    @(negedge clk);
    word = 36'o777777777777; bpPOS = 6'd20; bpSIZE = 6'd6; incr = 1'b0; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (6) @(posedge clk);
    #1 rst = 1'b1;
    #1 chk("async_rst_busy", {63'd0, busy}, 64'd0);
    @(negedge clk);
    rst = 1'b0;
    quiet = 0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (done || busy) quiet++;
    end
    chk("abort_no_done", 64'(quiet), 64'd0);
    chk("abort_byte", {28'd0, byteOUT}, 64'd0);
    chk("abort_pos", {58'd0, newPOS}, 64'd0);

    run_op(36'o123456701234, 0, 36, 1'b0, 36'd0, 0, 0);
    run_op(36'o123456701234, 3, 6, 1'b1, 36'o770000000000, 5, 0);
    run_op(36'o777777777777, 40, 6, 1'b0, 36'd0, 0, 0);
    run_op(36'o777777777777, 30, 12, 1'b0, 36'd0, 0, 0);
    run_op(36'o777777777777, 0, 0, 1'b0, 36'd0, 0, 0);
    run_op(36'o777777777777, 10, 6, 1'b0, 36'd0, 0, 3);
    run_op(36'o777777777777, 5, 6, 1'b0, 36'd0, 0, 6);
    run_op(36'o123456701234, 0, 36, 1'b1, 36'o525252525252, 1, 0);

    for (int i = 0; i < 40; i++) begin
      run_op(rand36(), $urandom_range(0, 45), $urandom_range(0, 40), 1'($urandom),
             rand36(), $urandom_range(0, 4),
             ($urandom_range(0, 3) == 0) ? $urandom_range(1, 5) : 0);
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
